// File: rtl/imem_loader_if.sv
// Program-load stream between the boot source and the instruction memory.
// The master side drives words; the slave side (the loader) returns ready.
interface imem_loader_if;
    logic        load_valid;
    logic        load_ready;
    logic [31:0] load_data;
    logic        load_last;

    modport master (
        output load_valid,
        output load_data,
        output load_last,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        input  load_last,
        output load_ready
    );
endinterface

// File: rtl/imem_loader.sv
// Writable instruction memory: streams a program in after reset, holds the CPU
// in reset while loading, then serves combinational fetches (unloaded = NOP).
module imem_loader #(
    parameter int          DEPTH    = 32,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     reset,
    imem_loader_if.slave             load_bus,
    input  logic                     reload,
    input  logic [31:0]              pc,
    output logic [31:0]              instruction,
    output logic                     cpu_reset,
    output logic                     load_done,
    output logic [$clog2(DEPTH):0]   words_loaded
);
    localparam int ADDR_W = $clog2(DEPTH);

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    state_t                r_state;
    logic [ADDR_W-1:0]     r_wr_ptr;
    logic [ADDR_W:0]       r_words_loaded;
    logic [DEPTH-1:0]      r_loaded;
    logic                  r_cpu_reset;
    logic                  r_load_done;
    logic [31:0]           r_rom [0:DEPTH-1];

    logic                  w_load_ready;
    logic                  w_accept;
    logic                  w_final_word;
    logic [ADDR_W-1:0]     w_idx;
    logic                  w_unused_pc;

    // Ready is a pure state decode so the source sees no path from its own valid.
    assign w_load_ready = (r_state == ST_LOAD);
    assign w_accept     = load_bus.load_valid && w_load_ready;
    assign w_final_word = load_bus.load_last || (r_wr_ptr == ADDR_W'(DEPTH - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_LOAD;
            r_wr_ptr       <= '0;
            r_words_loaded <= '0;
            r_loaded       <= '0;
            r_cpu_reset    <= 1'b1;
            r_load_done    <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_accept) begin
                        r_loaded[r_wr_ptr] <= 1'b1;
                        r_wr_ptr           <= r_wr_ptr + 1'b1;
                        if (r_words_loaded != (ADDR_W+1)'(DEPTH))
                            r_words_loaded <= r_words_loaded + 1'b1;
                        if (w_final_word) begin
                            r_state     <= ST_DONE;
                            r_cpu_reset <= 1'b0;
                            r_load_done <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    // Old rom contents stay; clearing the bitmap masks them.
                    if (reload) begin
                        r_state        <= ST_LOAD;
                        r_wr_ptr       <= '0;
                        r_words_loaded <= '0;
                        r_loaded       <= '0;
                        r_cpu_reset    <= 1'b1;
                        r_load_done    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_LOAD;
                end
            endcase
        end
    end

    // NOTE: the storage array has no reset; validity comes from r_loaded, which
    // keeps the array a plain RAM instead of DEPTH*32 resettable flops.
    always_ff @(posedge clk) begin
        if (w_accept)
            r_rom[r_wr_ptr] <= load_bus.load_data;
    end

    assign w_idx       = pc[ADDR_W+1:2];
    assign instruction = r_loaded[w_idx] ? r_rom[w_idx] : NOP_WORD;
    assign w_unused_pc = &{1'b0, pc[1:0], pc[31:ADDR_W+2]};

    assign load_bus.load_ready = w_load_ready;
    assign cpu_reset           = r_cpu_reset;
    assign load_done           = r_load_done;
    assign words_loaded        = r_words_loaded;
endmodule
